maxpool_relu: RTL and testbench

Pooling stage directly downstream of the convolution layer. Streams the convolution output buffer BRAM, takes a POOL×POOL stride-POOL signed maximum per channel with optional fused ReLU, and writes the reduced feature map into the pool buffer BRAM. Frames are CHW-linear: address = (ch·H + row)·W + col.

---
 rtl/maxpool_relu_if.sv | 22 ++
 rtl/maxpool_relu.sv | 119 +++++++++++
 tb/tb_maxpool_relu.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_relu_if.sv
// maxpool_relu_if: start/busy/done control plus conv-buffer read and pool-buffer write ports
interface maxpool_relu_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IAW = 13,
    parameter int OAW = 11
);
    logic start, busy, done;
    logic [IAW-1:0] in_addr;
    logic in_en;
    logic signed [DATA_WIDTH-1:0] in_q;
    logic [OAW-1:0] out_addr;
    logic out_en, out_we;
    logic signed [DATA_WIDTH-1:0] out_d;
    modport master(
        input start, in_q,
        output busy, done, in_addr, in_en, out_addr, out_en, out_we, out_d
    );
    modport slave(
        output start, in_q,
        input busy, done, in_addr, in_en, out_addr, out_en, out_we, out_d
    );
endinterface

// File: rtl/maxpool_relu.sv
// maxpool_relu: streams a CHW conv buffer, 2x2 stride-2 signed max per channel with optional ReLU
module maxpool_relu #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS = 8,
    parameter int IN_SIZE = 28,
    parameter int POOL = 2,
    parameter int RELU = 1
) (
    input logic clk,
    input logic reset,
    maxpool_relu_if.master bus
);
    localparam int OUT_SIZE = IN_SIZE / POOL;
    localparam int IAW = $clog2(CHANNELS * IN_SIZE * IN_SIZE);
    localparam int OAW = $clog2(CHANNELS * OUT_SIZE * OUT_SIZE);
    localparam int CW = $clog2(CHANNELS + 1);
    localparam int SW = $clog2(OUT_SIZE + 1);

    if (POOL != 2 || IN_SIZE % POOL != 0) begin : g_bad_cfg
        $error("maxpool_relu: only POOL=2 with IN_SIZE divisible by POOL is supported");
    end

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, FINISH} state_t;
    state_t state;
    logic [1:0] k;
    logic [CW-1:0] ch, n_ch, sc;
    logic [SW-1:0] orow, ocol, n_orow, n_ocol, sr, scol;
    logic [1:0] tap;
    logic vld, first;
    logic signed [DATA_WIDTH-1:0] mx, win_max, pooled;
    logic last_col, last_row, last_ch;
    logic [IAW-1:0] ia;
    logic [OAW-1:0] oa;

    assign last_col = ocol == SW'(OUT_SIZE - 1);
    assign last_row = orow == SW'(OUT_SIZE - 1);
    assign last_ch = ch == CW'(CHANNELS - 1);
    assign n_ocol = last_col ? '0 : ocol + 1'b1;
    assign n_orow = last_col ? (last_row ? '0 : orow + 1'b1) : orow;
    assign n_ch = (last_col && last_row) ? ch + 1'b1 : ch;
    // Read address targets the next tap: the upcoming window while writing, window 0 from idle
    assign sc = state == WRITE ? n_ch : state == IDLE ? '0 : ch;
    assign sr = state == WRITE ? n_orow : state == IDLE ? '0 : orow;
    assign scol = state == WRITE ? n_ocol : state == IDLE ? '0 : ocol;
    assign tap = state == FETCH ? k + 2'd1 : 2'd0;
    assign ia = IAW'((32'(sc) * IN_SIZE + 2 * 32'(sr) + 32'(tap[1])) * IN_SIZE + 2 * 32'(scol) + 32'(tap[0]));
    assign oa = OAW'((32'(ch) * OUT_SIZE + 32'(orow)) * OUT_SIZE + 32'(ocol));
    assign win_max = (first || bus.in_q > mx) ? bus.in_q : mx;
    assign pooled = (RELU != 0 && win_max < 0) ? '0 : win_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            k <= '0;
            ch <= '0;
            orow <= '0;
            ocol <= '0;
            vld <= 1'b0;
            first <= 1'b0;
            mx <= '0;
            bus.in_en <= 1'b0;
            bus.in_addr <= '0;
            bus.out_en <= 1'b0;
            bus.out_we <= 1'b0;
            bus.out_addr <= '0;
            bus.out_d <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            vld <= bus.in_en;
            first <= bus.in_en && k == 2'd0;
            if (vld) mx <= win_max;
            bus.out_en <= 1'b0;
            bus.out_we <= 1'b0;
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    ch <= '0;
                    orow <= '0;
                    ocol <= '0;
                    k <= '0;
                    bus.in_en <= 1'b1;
                    bus.in_addr <= ia;
                    bus.busy <= 1'b1;
                    state <= FETCH;
                end
                FETCH: begin
                    bus.in_en <= k != 2'd3;
                    bus.in_addr <= ia;
                    k <= k + 2'd1;
                    if (k == 2'd3) state <= WRITE;
                end
                WRITE: begin
                    bus.out_en <= 1'b1;
                    bus.out_we <= 1'b1;
                    bus.out_addr <= oa;
                    bus.out_d <= pooled;
                    if (last_col && last_row && last_ch) begin
                        bus.in_en <= 1'b0;
                        state <= FINISH;
                    end else begin
                        ch <= n_ch;
                        orow <= n_orow;
                        ocol <= n_ocol;
                        k <= '0;
                        bus.in_en <= 1'b1;
                        bus.in_addr <= ia;
                        state <= FETCH;
                    end
                end
                FINISH: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_maxpool_relu.sv
// tb_maxpool_relu: two instances (RELU=0/1) on a shared conv buffer, checked against a window-max model
module tb_maxpool_relu;
    localparam int DW = 16, CH = 2, IS = 4, OS = 2, N = CH * OS * OS, NI = CH * IS * IS;
    localparam int IAW = $clog2(NI), OAW = $clog2(N);

    typedef struct {int c; int addr; int data;} ev_t;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic signed [DW-1:0] mem [NI];
    logic signed [DW-1:0] a_q, b_q;
    int cyc = 0, checks = 0, failures = 0, we_bad = 0;
    ev_t wr_a[$], wr_b[$], rd_a[$];
    int done_c[$], busy_c[$];

    always #5 clk = ~clk;

    maxpool_relu_if #(.DATA_WIDTH(DW), .IAW(IAW), .OAW(OAW)) a();
    maxpool_relu_if #(.DATA_WIDTH(DW), .IAW(IAW), .OAW(OAW)) b();

    maxpool_relu #(.DATA_WIDTH(DW), .CHANNELS(CH), .IN_SIZE(IS), .POOL(2), .RELU(0))
        dut_a (.clk(clk), .reset(reset), .bus(a));
    maxpool_relu #(.DATA_WIDTH(DW), .CHANNELS(CH), .IN_SIZE(IS), .POOL(2), .RELU(1))
        dut_b (.clk(clk), .reset(reset), .bus(b));

    assign a.start = start;
    assign b.start = start;
    assign a.in_q = a_q;
    assign b.in_q = b_q;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a.in_en) a_q <= mem[a.in_addr];
        if (b.in_en) b_q <= mem[b.in_addr];
    end

    always @(negedge clk) begin
        if (a.out_we) wr_a.push_back('{cyc, int'(a.out_addr), int'(a.out_d)});
        if (b.out_we) wr_b.push_back('{cyc, int'(b.out_addr), int'(b.out_d)});
        if (a.in_en) rd_a.push_back('{cyc, int'(a.in_addr), 0});
        if (a.done) done_c.push_back(cyc);
        if (a.busy) busy_c.push_back(cyc);
        if (a.out_we !== a.out_en || b.out_we !== b.out_en) we_bad++;
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model(int w, bit relu);
        int c, r, col, m, v;
        c = w / (OS * OS);
        r = (w / OS) % OS;
        col = w % OS;
        m = mem[(c * IS + 2 * r) * IS + 2 * col];
        for (int t = 1; t < 4; t++) begin
            v = mem[(c * IS + 2 * r + t / 2) * IS + 2 * col + t % 2];
            if (v > m) m = v;
        end
        return (relu && m < 0) ? 0 : m;
    endfunction

    task automatic set_win(input int c, input int w, input int v[4]);
        for (int t = 0; t < 4; t++)
            mem[(c * IS + 2 * (w / OS) + t / 2) * IS + 2 * (w % OS) + t % 2] = 16'(v[t]);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NI; i++) mem[i] = 16'($urandom);
    endtask

    task automatic clear_logs();
        wr_a.delete();
        wr_b.delete();
        rd_a.delete();
        done_c.delete();
        busy_c.delete();
    endtask

    task automatic verify(input int s);
        int j, nb, bfirst, blast;
        int cnt [NI];
        j = 0;
        foreach (wr_a[i]) if (wr_a[i].c > s) begin
            check("wr_addr", wr_a[i].addr, j);
            check("wr_data", wr_a[i].data, model(j, 0));
            check("wr_cycle", wr_a[i].c, s + 6 + 5 * j);
            j++;
        end
        check("n_writes", j, N);
        j = 0;
        foreach (wr_b[i]) if (wr_b[i].c > s) begin
            check("relu_data", wr_b[i].data, model(j, 1));
            check("relu_cycle", wr_b[i].c, s + 6 + 5 * j);
            j++;
        end
        check("n_writes_relu", j, N);
        foreach (cnt[i]) cnt[i] = 0;
        j = 0;
        foreach (rd_a[i]) if (rd_a[i].c > s) begin
            check("rd_cycle", rd_a[i].c, s + 1 + 5 * (j / 4) + j % 4);
            if (rd_a[i].addr < NI) cnt[rd_a[i].addr]++;
            j++;
        end
        check("n_reads", j, 4 * N);
        nb = 0;
        foreach (cnt[i]) if (cnt[i] != 1) nb++;
        check("rd_cover", nb, 0);
        j = 0;
        foreach (done_c[i]) if (done_c[i] > s) begin
            check("done_cycle", done_c[i], s + 5 * N + 2);
            j++;
        end
        check("n_done", j, 1);
        nb = 0;
        bfirst = -1;
        blast = -1;
        foreach (busy_c[i]) if (busy_c[i] > s && busy_c[i] <= s + 5 * N + 2) begin
            if (bfirst < 0) bfirst = busy_c[i];
            blast = busy_c[i];
            nb++;
        end
        check("busy_len", nb, 5 * N + 1);
        check("busy_first", bfirst, s + 1);
        check("busy_last", blast, s + 5 * N + 1);
        check("we_eq_en", we_bad, 0);
    endtask

    task automatic run_pass(input bit repulse, input bit chained, output int s);
        bit got_done;
        got_done = 0;
        if (!chained) @(negedge clk);
        clear_logs();
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && !got_done; i++) begin
            @(negedge clk);
            start = repulse && (cyc == s + 10 || cyc == s + 23);
            if (a.done) got_done = 1;
        end
        start = 1'b0;
        check("done_seen", got_done, 1);
        #1;
        verify(s);
    endtask

    initial begin
        int s, n;
        int basic[16] = '{1, 5, 2, 3, 4, 0, 7, -1, -9, -8, 3, 3, -2, -7, 6, 2};
        int exp_basic[8] = '{5, 7, -2, 6, 105, 107, 98, 106};
        repeat (3) @(negedge clk);
        check("rst_in_en", a.in_en, 0);
        check("rst_in_addr", a.in_addr, 0);
        check("rst_out_en", a.out_en, 0);
        check("rst_out_we", a.out_we, 0);
        check("rst_out_addr", a.out_addr, 0);
        check("rst_out_d", a.out_d, 0);
        check("rst_busy", a.busy, 0);
        check("rst_done", a.done, 0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            mem[i] = 16'(basic[i]);
            mem[16 + i] = 16'(basic[i] + 100);
        end
        run_pass(0, 0, s);
        for (int i = 0; i < wr_a.size() && i < 8; i++) check("basic_const", wr_a[i].data, exp_basic[i]);

        fill_random();
        set_win(0, 0, '{-32768, 32767, 0, -1});
        set_win(0, 1, '{-32768, -32768, -32768, -32768});
        set_win(0, 2, '{-3, -1, -4, -2});
        run_pass(1, 0, s);
        if (wr_a.size() >= 3 && wr_b.size() >= 3) begin
            check("ext_mixed", wr_a[0].data, 32767);
            check("ext_allmin", wr_a[1].data, -32768);
            check("neg_norelu", wr_a[2].data, -1);
            check("neg_relu", wr_b[2].data, 0);
        end else check("ext_count", wr_a.size(), N);

        for (int p = 0; p < 4; p++) begin
            fill_random();
            run_pass(p[0] | ($urandom_range(0, 1) == 1), 1, s);
        end

        fill_random();
        @(negedge clk);
        clear_logs();
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_in_en", a.in_en, 0);
        check("mid_in_addr", a.in_addr, 0);
        check("mid_out_we", a.out_we, 0);
        check("mid_out_en", a.out_en, 0);
        check("mid_out_addr", a.out_addr, 0);
        check("mid_out_d", a.out_d, 0);
        check("mid_busy", a.busy, 0);
        check("mid_done", a.done, 0);
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (60) @(negedge clk);
        n = 0;
        foreach (rd_a[i]) if (rd_a[i].c > s + 10) n++;
        foreach (wr_a[i]) if (wr_a[i].c > s + 10) n++;
        foreach (busy_c[i]) if (busy_c[i] > s + 10) n++;
        n += done_c.size();
        check("rst_quiet", n, 0);

        fill_random();
        run_pass(0, 0, s);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
